fpu_req_arbiter: RTL and testbench

- Shares the single-precision FPU datapath among NREQ requesters.
- Arbitrates round-robin and accepts one operation at a time.
- Drives registered operands/opcode into the FPU, waits a fixed FPU latency, then captures the result and exception flags.
- Returns the result with a requester ID over a valid/ready response channel; also keeps sticky exception flags for software.

---
 rtl/fpu_req_arbiter_if.sv | 45 ++++
 rtl/fpu_req_arbiter.sv | 137 +++++++++++++
 tb/tb_fpu_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_req_arbiter_if.sv
// rtl/fpu_req_arbiter_if.sv - requester, FPU and response bundle for fpu_req_arbiter
interface fpu_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_opa;
  logic [32*NREQ-1:0] req_opb;
  logic [5*NREQ-1:0]  req_op_code;
  logic [2*NREQ-1:0]  req_mode;

  logic [31:0]        fpu_opa;
  logic [31:0]        fpu_opb;
  logic [4:0]         fpu_op_code;
  logic [1:0]         fpu_mode;
  logic [31:0]        fpu_out;
  logic [4:0]         fpu_flags;

  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_data;
  logic [4:0]         resp_flags;

  logic [4:0]         sticky_flags;
  logic               sticky_clr;
  logic               busy;

  // Requesters, response consumer and the FPU model all sit on this side.
  modport master (
    output req_valid, req_opa, req_opb, req_op_code, req_mode,
    output fpu_out, fpu_flags, resp_ready, sticky_clr,
    input  req_ready, fpu_opa, fpu_opb, fpu_op_code, fpu_mode,
    input  resp_valid, resp_id, resp_data, resp_flags, sticky_flags, busy
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_opa, req_opb, req_op_code, req_mode,
    input  fpu_out, fpu_flags, resp_ready, sticky_clr,
    output req_ready, fpu_opa, fpu_opb, fpu_op_code, fpu_mode,
    output resp_valid, resp_id, resp_data, resp_flags, sticky_flags, busy
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// rtl/fpu_req_arbiter.sv - round-robin arbiter sharing one FPU among NREQ requesters
module fpu_req_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  fpu_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  grant_idx;
  logic [3:0]      cnt;
  logic            any_valid;
  logic [NREQ-1:0] ready_vec;
  logic            accept;
  logic            finish;
  logic            handshake;
  logic [31:0]     sel_opa;
  logic [31:0]     sel_opb;
  logic [4:0]      sel_op_code;
  logic [1:0]      sel_mode;

  // Find the first requesting index after the previous grant, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  // Pull the granted requester's fields out of the packed request buses.
  always_comb begin
    sel_opa     = bus.req_opa[32*int'(grant_idx) +: 32];
    sel_opb     = bus.req_opb[32*int'(grant_idx) +: 32];
    sel_op_code = bus.req_op_code[5*int'(grant_idx) +: 5];
    sel_mode    = bus.req_mode[2*int'(grant_idx) +: 2];
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the accept, capture and response-handshake strobes.
  always_comb begin
    state_nxt = state;
    ready_vec = '0;
    accept    = 1'b0;
    finish    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          ready_vec[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_nxt            = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand launch, latency countdown, result capture and sticky flag accumulation.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      bus.fpu_opa      <= '0;
      bus.fpu_opb      <= '0;
      bus.fpu_op_code  <= '0;
      bus.fpu_mode     <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_id      <= '0;
      bus.resp_data    <= '0;
      bus.resp_flags   <= '0;
      bus.sticky_flags <= '0;
      gid              <= '0;
      last_grant       <= IDW'(NREQ - 1);
      cnt              <= '0;
    end else begin
      if (accept) begin
        bus.fpu_opa     <= sel_opa;
        bus.fpu_opb     <= sel_opb;
        bus.fpu_op_code <= sel_op_code;
        bus.fpu_mode    <= sel_mode;
        gid             <= grant_idx;
        last_grant      <= grant_idx;
        cnt             <= 4'(LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (finish) begin
        bus.resp_data  <= bus.fpu_out;
        bus.resp_flags <= bus.fpu_flags;
        bus.resp_id    <= gid;
        bus.resp_valid <= 1'b1;
      end
      if (handshake) begin
        bus.resp_valid   <= 1'b0;
        bus.sticky_flags <= bus.sticky_flags | bus.resp_flags;
      end
      // A clear on the same edge as a handshake drops that response's flags.
      if (bus.sticky_clr) begin
        bus.sticky_flags <= '0;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb/tb_fpu_req_arbiter.sv - directed self-checking bench for fpu_req_arbiter
module tb_fpu_req_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   tests  = 0;
  int   fails  = 0;

  always #5 clk_in = ~clk_in;

  fpu_req_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus_a ();
  fpu_req_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus_b ();

  fpu_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(1)) dut_a (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_a.slave)
  );

  fpu_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(3)) dut_b (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic set_req_a(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [1:0] md);
    bus_a.req_opa[32*i +: 32]   = a;
    bus_a.req_opb[32*i +: 32]   = b;
    bus_a.req_op_code[5*i +: 5] = op;
    bus_a.req_mode[2*i +: 2]    = md;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req_valid = '0; bus_a.req_opa = '0; bus_a.req_opb = '0;
    bus_a.req_op_code = '0; bus_a.req_mode = '0;
    bus_a.fpu_out = '0; bus_a.fpu_flags = '0;
    bus_a.resp_ready = 1'b1; bus_a.sticky_clr = 1'b0;
    bus_b.req_valid = '0; bus_b.req_opa = '0; bus_b.req_opb = '0;
    bus_b.req_op_code = '0; bus_b.req_mode = '0;
    bus_b.fpu_out = '0; bus_b.fpu_flags = '0;
    bus_b.resp_ready = 1'b0; bus_b.sticky_clr = 1'b0;

    // Power-on reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_busy",       32'(bus_a.busy),         32'h0);
    chk("rst_resp_valid", 32'(bus_a.resp_valid),   32'h0);
    chk("rst_resp_id",    32'(bus_a.resp_id),      32'h0);
    chk("rst_resp_data",  bus_a.resp_data,         32'h0);
    chk("rst_resp_flags", 32'(bus_a.resp_flags),   32'h0);
    chk("rst_sticky",     32'(bus_a.sticky_flags), 32'h0);
    chk("rst_fpu_opa",    bus_a.fpu_opa,           32'h0);
    chk("rst_fpu_opcode", 32'(bus_a.fpu_op_code),  32'h0);
    chk("rst_req_ready",  32'(bus_a.req_ready),    32'h0);

    // Single op from requester 2, LAT=1
    set_req_a(2, 32'h3F800000, 32'h40000000, 5'd0, 2'd0);
    bus_a.req_valid = 4'b0100;
    #1;
    chk("single_grant", 32'(bus_a.req_ready), 32'h4);
    chk("single_idle",  32'(bus_a.busy),      32'h0);
    step();
    bus_a.req_valid = '0;
    bus_a.fpu_out   = 32'h40400000;
    bus_a.fpu_flags = 5'b00000;
    #1;
    chk("single_busy",   32'(bus_a.busy),       32'h1);
    chk("single_opa",    bus_a.fpu_opa,         32'h3F800000);
    chk("single_opb",    bus_a.fpu_opb,         32'h40000000);
    chk("single_nvalid", 32'(bus_a.resp_valid), 32'h0);
    step();
    chk("single_valid", 32'(bus_a.resp_valid), 32'h1);
    chk("single_id",    32'(bus_a.resp_id),    32'h2);
    chk("single_data",  bus_a.resp_data,       32'h40400000);
    step();
    chk("single_done_busy",  32'(bus_a.busy),       32'h0);
    chk("single_done_valid", 32'(bus_a.resp_valid), 32'h0);

    // Backpressure with requester 1 pending; first op also feeds the sticky flags
    bus_a.resp_ready = 1'b0;
    set_req_a(0, 32'hA0A0A0A0, 32'h0, 5'd1, 2'd0);
    bus_a.req_valid = 4'b0001;
    #1;
    chk("bp_grant0", 32'(bus_a.req_ready), 32'h1);
    step();
    set_req_a(1, 32'h51515151, 32'h15151515, 5'd3, 2'd1);
    bus_a.req_valid = 4'b0010;
    bus_a.fpu_out   = 32'h11112222;
    bus_a.fpu_flags = 5'b01000;
    #1;
    chk("bp_wait_ready", 32'(bus_a.req_ready), 32'h0);
    step();
    bus_a.fpu_out   = 32'hFFFFFFFF;
    bus_a.fpu_flags = 5'b11111;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(bus_a.resp_valid), 32'h1);
      chk("bp_data",  bus_a.resp_data,       32'h11112222);
      chk("bp_id",    32'(bus_a.resp_id),    32'h0);
      chk("bp_flags", 32'(bus_a.resp_flags), 32'h08);
      chk("bp_ready", 32'(bus_a.req_ready),  32'h0);
      step();
    end
    bus_a.resp_ready = 1'b1;
    #1;
    chk("bp_hs_ready", 32'(bus_a.req_ready), 32'h0);
    step();
    chk("bp_grant1",  32'(bus_a.req_ready),    32'h2);
    chk("bp_sticky1", 32'(bus_a.sticky_flags), 32'h08);
    chk("bp_cleared", 32'(bus_a.resp_valid),   32'h0);
    step();
    bus_a.req_valid = '0;
    bus_a.fpu_out   = 32'h33334444;
    bus_a.fpu_flags = 5'b00100;
    #1;
    chk("op2_opa",  bus_a.fpu_opa,          32'h51515151);
    chk("op2_code", 32'(bus_a.fpu_op_code), 32'h3);
    chk("op2_mode", 32'(bus_a.fpu_mode),    32'h1);
    step();
    chk("op2_valid", 32'(bus_a.resp_valid), 32'h1);
    chk("op2_id",    32'(bus_a.resp_id),    32'h1);
    chk("op2_data",  bus_a.resp_data,       32'h33334444);
    chk("op2_flags", 32'(bus_a.resp_flags), 32'h04);
    step();
    chk("sticky_or", 32'(bus_a.sticky_flags), 32'h0C);
    chk("op2_idle",  32'(bus_a.busy),         32'h0);

    // Reset in the middle of WAIT discards the op
    set_req_a(3, 32'hDEADBEEF, 32'h1, 5'd2, 2'd2);
    bus_a.req_valid = 4'b1000;
    #1;
    chk("mid_grant3", 32'(bus_a.req_ready), 32'h8);
    step();
    bus_a.req_valid = '0;
    #1;
    chk("mid_opa",  bus_a.fpu_opa,    32'hDEADBEEF);
    chk("mid_busy", 32'(bus_a.busy),  32'h1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(bus_a.resp_valid),   32'h0);
    chk("mid_rst_busy",   32'(bus_a.busy),         32'h0);
    chk("mid_rst_sticky", 32'(bus_a.sticky_flags), 32'h0);
    chk("mid_rst_opa",    bus_a.fpu_opa,           32'h0);
    step();
    step();
    chk("mid_no_resp", 32'(bus_a.resp_valid), 32'h0);

    // Round robin with all requesters held high
    for (int i = 0; i < NREQ; i++) begin
      set_req_a(i, 32'h10000000 * 32'(i + 1), 32'(i), 5'(i), 2'(i));
    end
    bus_a.fpu_out    = 32'hCAFEF00D;
    bus_a.fpu_flags  = 5'b00001;
    bus_a.resp_ready = 1'b1;
    bus_a.req_valid  = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      int w;
      w = 0;
      while (bus_a.req_ready == '0 && w < 20) begin
        step();
        w++;
      end
      chk("rr_grant", 32'(bus_a.req_ready), 32'h1 << (g % 4));
      step();
      chk("rr_pulse", 32'(bus_a.req_ready), 32'h0);
      chk("rr_opa",   bus_a.fpu_opa,        32'h10000000 * 32'((g % 4) + 1));
      step();
      chk("rr_valid", 32'(bus_a.resp_valid), 32'h1);
      chk("rr_id",    32'(bus_a.resp_id),    32'(g % 4));
      step();
    end
    bus_a.req_valid = '0;
    #1;
    chk("rr_sticky", 32'(bus_a.sticky_flags), 32'h01);

    // sticky_clr coincident with a response handshake wins
    set_req_a(2, 32'h0BADCAFE, 32'h2, 5'd4, 2'd3);
    bus_a.resp_ready = 1'b0;
    bus_a.fpu_out    = 32'h77778888;
    bus_a.fpu_flags  = 5'b10000;
    bus_a.req_valid  = 4'b0100;
    #1;
    chk("clr_grant", 32'(bus_a.req_ready), 32'h4);
    step();
    bus_a.req_valid = '0;
    step();
    chk("clr_valid", 32'(bus_a.resp_valid), 32'h1);
    chk("clr_flags", 32'(bus_a.resp_flags), 32'h10);
    bus_a.sticky_clr = 1'b1;
    bus_a.resp_ready = 1'b1;
    step();
    bus_a.sticky_clr = 1'b0;
    #1;
    chk("clr_sticky", 32'(bus_a.sticky_flags), 32'h0);
    chk("clr_done",   32'(bus_a.resp_valid),   32'h0);
    chk("clr_idle",   32'(bus_a.busy),         32'h0);

    // LAT=3 instance: operands held three cycles, fpu_out sampled at the end of the third
    bus_b.req_opa[31:0] = 32'h12345678;
    bus_b.req_opb[31:0] = 32'h87654321;
    bus_b.req_valid     = 4'b0001;
    #1;
    chk("l3_grant", 32'(bus_b.req_ready), 32'h1);
    step();
    bus_b.req_valid = '0;
    bus_b.fpu_out   = 32'hBAD0BAD0;
    bus_b.fpu_flags = 5'b11111;
    #1;
    chk("l3_opa_1",   bus_b.fpu_opa,         32'h12345678);
    chk("l3_busy",    32'(bus_b.busy),       32'h1);
    chk("l3_nvalid1", 32'(bus_b.resp_valid), 32'h0);
    step();
    chk("l3_opa_2",   bus_b.fpu_opa,         32'h12345678);
    chk("l3_nvalid2", 32'(bus_b.resp_valid), 32'h0);
    step();
    chk("l3_opb_3",   bus_b.fpu_opb,         32'h87654321);
    chk("l3_nvalid3", 32'(bus_b.resp_valid), 32'h0);
    bus_b.fpu_out   = 32'h0600D000;
    bus_b.fpu_flags = 5'b00010;
    step();
    chk("l3_valid", 32'(bus_b.resp_valid), 32'h1);
    chk("l3_data",  bus_b.resp_data,       32'h0600D000);
    chk("l3_flags", 32'(bus_b.resp_flags), 32'h02);
    bus_b.resp_ready = 1'b1;
    step();
    chk("l3_idle",   32'(bus_b.busy),         32'h0);
    chk("l3_sticky", 32'(bus_b.sticky_flags), 32'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
